// File: rtl/ram_pattern_checker.sv
// rtl/ram_pattern_checker.sv - read-side BIST sweep of a block RAM against its power-on pattern
//
// Purpose: on start, reads addresses 0..DEPTH-1 from a RAM with a 1-cycle
// synchronous read port. Each word is compared against PATTERN[addr mod 10].
// The block reports done/pass, a saturating error count and the first failing
// address and data.
//
// Ports:
//   clk_i             clock, all state on posedge
//   rst_n_i           asynchronous active-low reset
//   start_i           single-cycle sweep request, ignored while busy
//   rden_o            RAM read enable
//   rdaddr_o          RAM read address (registered)
//   do_i              RAM read data, valid one edge after rdaddr_o is sampled
//   busy_o            sweep in progress
//   done_o            sweep finished, held until next start or reset
//   pass_o            done with zero errors
//   err_count_o       saturating mismatch count
//   first_err_addr_o  address of the first mismatch
//   first_err_data_o  data read at the first mismatch
module ram_pattern_checker #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 511,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  output logic                  rden_o,
  output logic [ADDR_WIDTH-1:0] rdaddr_o,
  input  logic [DATA_WIDTH-1:0] do_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ERR_WIDTH-1:0]  err_count_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic [DATA_WIDTH-1:0] first_err_data_o
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ERR_WIDTH-1:0]  ERR_MAX   = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rdaddr_q, rdaddr_d;
  logic [3:0]            idx_q, idx_d;
  logic                  cmp_v_q, cmp_v_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic [3:0]            cmp_idx_q, cmp_idx_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [ADDR_WIDTH-1:0] fa_q, fa_d;
  logic [DATA_WIDTH-1:0] fd_q, fd_d;
  logic                  start_ok;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [3:0] idx);
    logic [63:0] p;
    case (idx)
      4'd0:    p = 64'h0000000000000001;
      4'd1:    p = 64'hAAAAAAAAAAAAAAAA;
      4'd2:    p = 64'h5555555555555555;
      4'd3:    p = 64'hFFFFFFFFFFFFFFFF;
      4'd4:    p = 64'hF0F0F0F0F0F0F0F0;
      4'd5:    p = 64'h0F0F0F0F0F0F0F0F;
      4'd6:    p = 64'hCCCCCCCCCCCCCCCC;
      4'd7:    p = 64'h3333333333333333;
      4'd8:    p = 64'h0002000200020002;
      default: p = 64'h0004000400040004;
    endcase
    return p[DATA_WIDTH-1:0];
  endfunction

  assign start_ok = start_i && ((state_q == IDLE) || (state_q == DONE));

  // State register and all datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      rdaddr_q   <= '0;
      idx_q      <= '0;
      cmp_v_q    <= 1'b0;
      cmp_addr_q <= '0;
      cmp_idx_q  <= '0;
      err_q      <= '0;
      fa_q       <= '0;
      fd_q       <= '0;
    end else begin
      state_q    <= state_d;
      rdaddr_q   <= rdaddr_d;
      idx_q      <= idx_d;
      cmp_v_q    <= cmp_v_d;
      cmp_addr_q <= cmp_addr_d;
      cmp_idx_q  <= cmp_idx_d;
      err_q      <= err_d;
      fa_q       <= fa_d;
      fd_q       <= fd_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_ok) state_d = SWEEP;
      // Leave once the last address has been held on the port for one edge,
      // so the RAM has sampled it.
      SWEEP: if (rdaddr_q == LAST_ADDR) state_d = DRAIN;
      // Exactly one word is still in flight when DRAIN is entered.
      DRAIN: state_d = DONE;
      DONE:  if (start_ok) state_d = SWEEP;
      default: state_d = IDLE;
    endcase
  end

  // Address sequencing and compare datapath
  always_comb begin
    rdaddr_d   = rdaddr_q;
    idx_d      = idx_q;
    // Stage tags follow the address that the RAM samples at this edge.
    // Its data arrives on do_i in time for the next edge.
    cmp_v_d    = (state_q == SWEEP);
    cmp_addr_d = rdaddr_q;
    cmp_idx_d  = idx_q;
    err_d      = err_q;
    fa_d       = fa_q;
    fd_d       = fd_q;

    if (start_ok) begin
      rdaddr_d = '0;
      idx_d    = '0;
      err_d    = '0;
      fa_d     = '0;
      fd_d     = '0;
    end else begin
      if ((state_q == SWEEP) && (rdaddr_q != LAST_ADDR)) begin
        rdaddr_d = rdaddr_q + 1'b1;
        idx_d    = (idx_q == 4'd9) ? 4'd0 : idx_q + 4'd1;
      end
      if (cmp_v_q && (do_i != pattern(cmp_idx_q))) begin
        if (err_q != ERR_MAX) err_d = err_q + 1'b1;
        // A saturated counter never returns to zero, so zero means first error.
        if (err_q == '0) begin
          fa_d = cmp_addr_q;
          fd_d = do_i;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    rden_o = (state_q == SWEEP);
    busy_o = (state_q == SWEEP) || (state_q == DRAIN);
    done_o = (state_q == DONE);
    pass_o = (state_q == DONE) && (err_q == '0);
  end

  assign rdaddr_o         = rdaddr_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = fa_q;
  assign first_err_data_o = fd_q;

endmodule
